// File: rtl/debug_pkg.sv
// Shared constants and FSM encoding for the debug dump serializer.
package debug_pkg;
  localparam logic [7:0] HEADER_BYTE         = 8'hA5;
  localparam int         FRAME_PAYLOAD_BYTES = 184;
  localparam int         IDEX_PAD_W          = 128;

  // Byte offsets of each field inside the snapshot / payload stream
  localparam int IFID_OFF = 0;
  localparam int IDEX_OFF = 8;
  localparam int REG_OFF  = 24;
  localparam int MEM_OFF  = 152;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHKSUM  = 3'd3,
    ST_DONE    = 3'd4
  } dbg_state_e;
endpackage

// File: rtl/dbg_byte_mux.sv
// Combinational snapshot-to-byte selector; byte k is snap[8k+7:8k].
module dbg_byte_mux #(
  parameter int NBYTES = 184
) (
  input  logic [NBYTES*8-1:0] snap,
  input  logic [7:0]          idx,
  output logic [7:0]          byte_out
);
  // Out-of-range indices return zero rather than X
  assign byte_out = (idx < 8'(NBYTES)) ? snap[{idx, 3'b000} +: 8] : 8'h00;
endmodule

// File: rtl/debug_dump_serializer.sv
// Snapshots the DataPath debug buses on a dump trigger and streams them
// as a framed byte sequence (header, payload, XOR checksum) over valid/ready.
module debug_dump_serializer import debug_pkg::*; #(
  parameter int         REG_W  = 1024,
  parameter int         MEM_W  = 256,
  parameter int         IFID_W = 64,
  parameter int         IDEX_W = 126,
  parameter logic [7:0] HEADER = HEADER_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  du_reg,
  input  logic [MEM_W-1:0]  du_mem,
  input  logic [IFID_W-1:0] du_if_id,
  input  logic [IDEX_W-1:0] du_id_ex,
  input  logic              du_halt,
  input  logic              dump_req,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);
  localparam int         SNAP_W = FRAME_PAYLOAD_BYTES * 8;
  localparam logic [7:0] LAST   = 8'(FRAME_PAYLOAD_BYTES - 1);

  dbg_state_e        state, state_nxt;
  logic              halt_q;
  logic [7:0]        cnt;
  logic [7:0]        csum;
  logic [SNAP_W-1:0] snap, snap_d;
  logic [7:0]        pay_byte;
  logic              trig;

  // Rising halt edge or explicit request; only acted on in IDLE
  assign trig = (du_halt & ~halt_q) | dump_req;

  // Assemble the snapshot image: if_id, padded id_ex, reg, mem (LSB first)
  always_comb begin
    snap_d = '0;
    snap_d[IFID_OFF*8 +: IFID_W] = du_if_id;
    snap_d[IDEX_OFF*8 +: IDEX_W] = du_id_ex;
    snap_d[REG_OFF*8  +: REG_W]  = du_reg;
    snap_d[MEM_OFF*8  +: MEM_W]  = du_mem;
  end

  dbg_byte_mux #(.NBYTES(FRAME_PAYLOAD_BYTES)) u_mux (
    .snap     (snap),
    .idx      (cnt),
    .byte_out (pay_byte)
  );

  // State, halt edge detector, snapshot, byte counter and running checksum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      halt_q <= 1'b0;
      cnt    <= '0;
      csum   <= '0;
      snap   <= '0;
    end else begin
      state  <= state_nxt;
      halt_q <= du_halt;
      if (state == ST_IDLE && trig) snap <= snap_d;
      if (state == ST_HEADER && tx_ready) begin
        cnt  <= '0;
        csum <= '0;
      end else if (state == ST_PAYLOAD && tx_ready) begin
        cnt  <= cnt + 8'd1;
        csum <= csum ^ pay_byte;
      end
    end
  end

  // Next-state and Moore outputs; data is held stable until accepted
  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (trig) state_nxt = ST_HEADER;
      ST_HEADER: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = pay_byte;
        if (tx_ready && cnt == LAST) state_nxt = ST_CHKSUM;
      end
      ST_CHKSUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_debug_dump_serializer.sv
// Randomized self-checking bench for debug_dump_serializer.
module tb_debug_dump_serializer;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1023:0] du_reg = '0;
  logic [255:0]  du_mem = '0;
  logic [63:0]   du_if_id = '0;
  logic [125:0]  du_id_ex = '0;
  logic          du_halt = 1'b0;
  logic          dump_req = 1'b0;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid, busy, done;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int done_cyc, dones, stable_err;
  logic busy_first;

  debug_dump_serializer dut (
    .clk(clk), .reset(reset), .du_reg(du_reg), .du_mem(du_mem),
    .du_if_id(du_if_id), .du_id_ex(du_id_ex), .du_halt(du_halt),
    .dump_req(dump_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference frame: header, fields LSB-first in order if_id/id_ex/reg/mem, XOR
  function automatic void build_exp();
    logic [7:0]   b;
    logic [7:0]   x;
    logic [127:0] idex;
    x = 8'h00;
    idex = {2'b00, du_id_ex};
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 184; i++) begin
      if (i < 8)        b = 8'(du_if_id >> (8 * i));
      else if (i < 24)  b = 8'(idex >> (8 * (i - 8)));
      else if (i < 152) b = 8'(du_reg >> (8 * (i - 24)));
      else              b = 8'(du_mem >> (8 * (i - 152)));
      exp_q.push_back(b);
      x ^= b;
    end
    exp_q.push_back(x);
  endfunction

  function automatic int first_diff();
    int n;
    n = (got.size() > exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (i >= got.size() || i >= exp_q.size() || got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i >= 0 && i < got.size()) ? got[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'hxx;
  endfunction

  task automatic randomize_buses();
    for (int i = 0; i < 32; i++) du_reg[32*i +: 32] = $urandom();
    for (int i = 0; i < 8; i++)  du_mem[32*i +: 32] = $urandom();
    du_if_id = {$urandom(), $urandom()};
    du_id_ex = {30'($urandom()), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic pulse_req();
    @(negedge clk);
    dump_req = 1'b1;
    @(posedge clk);
    #1 dump_req = 1'b0;
  endtask

  // Sink model: one sample per cycle starting the cycle after the trigger edge.
  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random.
  task automatic collect(input int mode, input int max_cyc);
    logic pv, r;
    logic [7:0] pd;
    pv = 1'b0; pd = '0;
    got.delete(); done_cyc = -1; dones = 0; stable_err = 0; busy_first = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      else                r = 1'($urandom_range(0, 1));
      tx_ready = r;
      if (c == 1) busy_first = busy;
      if (pv && (!tx_valid || tx_data !== pd)) stable_err++;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (tx_valid && r) got.push_back(tx_data);
      pv = tx_valid && !r;
      pd = tx_data;
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({tx_valid, busy, done} !== 3'b000 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got valid/busy/done=%b data=%h want 000 data=00",
               {tx_valid, busy, done}, tx_data);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_dump();
    int d;
    du_reg = '0; du_mem = '0; du_id_ex = '0;
    du_if_id = 64'h0123456789ABCDEF;
    build_exp();
    pulse_req();
    collect(0, 200);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL single_bytes: idx %0d got %h want %h", d, got_at(d), exp_at(d));
    end
    checks++;
    if (got_at(0) !== 8'hA5 || got_at(1) !== 8'hEF || got_at(8) !== 8'h01 || got_at(185) !== 8'h00) begin
      errors++;
      $display("FAIL single_literal: got %h %h %h %h want a5 ef 01 00",
               got_at(0), got_at(1), got_at(8), got_at(185));
    end
    checks++;
    if (done_cyc !== 187 || dones !== 1) begin
      errors++;
      $display("FAIL single_done: got cyc %0d count %0d want cyc 187 count 1", done_cyc, dones);
    end
    checks++;
    if (busy_first !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b want 1", busy_first);
    end
  endtask

  task automatic test_halt_edge();
    int d;
    du_reg = '0; du_mem = '0; du_if_id = '0; du_id_ex = '0;
    du_reg[63:32] = 32'hDEADBEEF;
    build_exp();
    @(negedge clk);
    du_halt = 1'b1;
    @(posedge clk);
    #1;
    collect(0, 450);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL halt_bytes: idx %0d got %h want %h", d, got_at(d), exp_at(d));
    end
    checks++;
    if ({got_at(29), got_at(30), got_at(31), got_at(32)} !== 32'hEFBEADDE) begin
      errors++;
      $display("FAIL halt_reg1: got %h%h%h%h want efbeadde",
               got_at(29), got_at(30), got_at(31), got_at(32));
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL halt_single_frame: got %0d frames want 1", dones);
    end
    du_halt = 1'b0;
  endtask

  task automatic test_backpressure();
    int d;
    logic [7:0] ref_q[$];
    randomize_buses();
    build_exp();
    pulse_req();
    collect(0, 200);
    ref_q = got;
    pulse_req();
    collect(1, 500);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL bp_bytes: idx %0d got %h want %h", d, got_at(d), exp_at(d));
    end
    checks++;
    if (got != ref_q) begin
      errors++;
      $display("FAIL bp_vs_free: got %0d bytes, differs from %0d-byte free-running frame",
               got.size(), ref_q.size());
    end
    checks++;
    if (stable_err !== 0 || dones !== 1) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable holds, %0d dones want 0, 1", stable_err, dones);
    end
  endtask

  task automatic test_snapshot_isolation();
    int d;
    randomize_buses();
    build_exp();
    pulse_req();
    fork
      collect(0, 200);
      begin
        repeat (80) @(negedge clk);
        du_mem = '1;
        du_reg = '0;
      end
    join
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL isolation_bytes: idx %0d got %h want %h", d, got_at(d), exp_at(d));
    end
  endtask

  task automatic test_trigger_busy();
    int d;
    randomize_buses();
    build_exp();
    pulse_req();
    fork
      collect(0, 420);
      begin
        repeat (51) @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
      end
    join
    d = first_diff();
    checks++;
    if (d >= 0 || dones !== 1) begin
      errors++;
      $display("FAIL busy_ignore: idx %0d dones %0d bytes %0d want -1, 1, 186",
               d, dones, got.size());
    end
  endtask

  task automatic test_random();
    int d;
    for (int it = 0; it < 3; it++) begin
      randomize_buses();
      build_exp();
      pulse_req();
      collect(2, 700);
      d = first_diff();
      checks++;
      if (d >= 0 || dones !== 1 || stable_err !== 0) begin
        errors++;
        $display("FAIL random_%0d: idx %0d got %h want %h dones %0d unstable %0d",
                 it, d, got_at(d), exp_at(d), dones, stable_err);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    randomize_buses();
    du_halt = 1'b0;
    pulse_req();
    tx_ready = 1'b1;
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_async: got valid/busy/done=%b want 000", {tx_valid, busy, done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_valid || busy || done) bad++;
    end
    tx_ready = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_mid_idle: got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_dump();
    test_halt_edge();
    test_backpressure();
    test_snapshot_isolation();
    test_trigger_busy();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/debug_dump_serializer.md
Name: debug_dump_serializer

Overview:
- Sits downstream of DataPath and consumes its debug-unit outputs: du_reg, du_mem, du_if_id, du_id_ex, du_halt.
- When a dump is triggered, it snapshots all four buses in one cycle.
- It then streams the snapshot as a framed byte sequence over a valid/ready byte interface to the UART transmitter.
- It is the bridge between the halted pipeline and the host-side debug tool.

Parameters:
- REG_W, 1024, width of du_reg (32 registers x 32 bits).
- MEM_W, 256, width of du_mem (8 words x 32 bits).
- IFID_W, 64, width of du_if_id.
- IDEX_W, 126, width of du_id_ex; zero-padded internally to 128.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- du_reg  in  REG_W  register file image from DataPath.
- du_mem  in  MEM_W  data memory image.
- du_if_id  in  IFID_W  IF/ID latch image.
- du_id_ex  in  IDEX_W  ID/EX latch image.
- du_halt  in  1  pipeline halted (level).
- dump_req  in  1  one-cycle software/host dump request.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts byte this cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after checksum byte accepted.

Behaviour:
- Reset (reset=0, async): state IDLE; tx_data=0, tx_valid=0, busy=0, done=0; halt_q=0; byte counter=0; checksum=0; snapshot register cleared.
- Trigger = (du_halt & ~halt_q) | dump_req, evaluated only in IDLE.
  - halt_q is du_halt registered every cycle, including while busy, so a halt that rises during a frame does not retrigger afterwards.
- On trigger in IDLE:
  - Snapshot register loads {mem, reg, 2'b00 & id_ex padded to 128, if_id} in that same edge. Total 1472 bits = 184 bytes.
  - State goes to HEADER; busy=1 from the next cycle.
- Triggers while busy are ignored (no queueing).
- Frame order: HEADER byte, then 184 payload bytes, then 1 checksum byte (186 bytes total).
- Payload field order: if_id, id_ex(128), reg, mem. Within each field, least-significant byte first.
- Payload byte k = snapshot[8k+7:8k], with k = 0..183.
- Checksum = XOR of the 184 payload bytes only. The header is excluded.
- Handshake:
  - A byte transfers on an edge where tx_valid & tx_ready.
  - tx_valid, once asserted, stays high with tx_data stable until accepted.
  - The next byte is presented the cycle after acceptance; tx_valid stays high back-to-back.
  - With tx_ready held high, throughput is 1 byte/cycle.
- States:
  - IDLE -> HEADER on trigger.
  - HEADER: tx_data=HEADER, tx_valid=1. On accept -> PAYLOAD, counter=0, checksum=0.
  - PAYLOAD: tx_data = byte[counter]. On accept: checksum ^= byte; counter++. At counter=183 -> CHKSUM.
  - CHKSUM: tx_data = checksum, which includes byte 183. On accept -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, tx_valid=0 -> IDLE.
- Latency: header is valid 1 cycle after the trigger edge. With tx_ready=1 throughout, done pulses 187 cycles after the trigger edge.
- The snapshot is immune to DataPath changes after the trigger. du_* inputs are sampled only at the trigger edge.
- tx_ready high while tx_valid=0 has no effect.
- Reset asserted mid-frame: immediate return to IDLE with tx_valid=0. No partial checksum or done is emitted.
  - If du_halt is still high at reset release, halt_q=0 causes a new dump on the first clock edge. This is intended: a fresh dump after reset.

Decomposition:
- Shared package debug_pkg: HEADER constant, FRAME_PAYLOAD_BYTES=184, field offset constants (IFID_OFF=0, IDEX_OFF=8, REG_OFF=24, MEM_OFF=152 in bytes), state encoding localparams.
- One sub-module is natural: dbg_byte_mux. It is a combinational 1472-bit to 8-bit selector indexed by the counter, kept separate so synthesis timing can be checked in isolation.
- FSM, counter, checksum and snapshot register stay in the top.

Test Plan:
- Single dump: du_if_id=64'h0123456789ABCDEF, other buses 0, pulse dump_req, tx_ready=1 -> bytes A5, EF, CD, AB, 89, 67, 45, 23, 01, then 176 x 00, checksum 00 (XOR of 01..EF pattern = 00); done 187 cycles after trigger.
- Halt edge: du_reg bit pattern with reg[1]=32'hDEADBEEF, raise du_halt and hold it -> exactly one frame. Payload bytes 28..31 = EF, BE, AD, DE. No second frame while du_halt stays high.
- Backpressure: tx_ready toggles 1,0,0,1 pattern -> tx_data never changes while valid&~ready; the 186 bytes are identical to the no-backpressure run.
- Snapshot isolation: after the trigger, change du_mem to all-ones mid-frame -> streamed mem bytes still equal the pre-trigger value.
- Trigger while busy: dump_req pulsed at byte 50 -> ignored; exactly one done, and no frame afterwards.
- Reset mid-frame: reset=0 at byte 100 -> tx_valid, busy and done all go to 0 asynchronously. After release with du_halt=0 and no request, the block stays IDLE.
